// File: rtl/rggen_apb_bridge.sv
// rggen bus slave -> APB4 master bridge, one transfer at a time.
// Optional ACCESS-phase timeout: define RGGEN_APB_BRIDGE_TIMEOUT_EN.
module rggen_apb_bridge #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bus_request,
  input  logic [ADDRESS_WIDTH-1:0]  bus_address,
  input  logic                      bus_direction,
  input  logic [DATA_WIDTH-1:0]     bus_write_data,
  input  logic [DATA_WIDTH/8-1:0]   bus_write_strobe,
  output logic                      bus_done,
  output logic [DATA_WIDTH-1:0]     bus_read_data,
  output logic [1:0]                bus_status,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [2:0]                pprot,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_WIDTH-1:0]     prdata
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    COMPLETE
  } state_t;

  state_t state;

  assign pprot = 3'b000;

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          expired;
  // Expiry lands on the last permitted wait cycle.
  assign expired = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus_done      <= 1'b0;
      bus_read_data <= '0;
      bus_status    <= 2'b00;
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      paddr         <= '0;
      pwdata        <= '0;
      pstrb         <= '0;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus_request) begin
            psel   <= 1'b1;
            paddr  <= bus_address;
            pwrite <= bus_direction;
            pwdata <= bus_write_data;
            pstrb  <= bus_direction ? bus_write_strobe : '0;
            state  <= SETUP;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel          <= 1'b0;
            penable       <= 1'b0;
            bus_read_data <= pwrite ? '0 : prdata;
            bus_status    <= {pslverr, 1'b0};
            bus_done      <= 1'b1;
            state         <= COMPLETE;
          end
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
          else if (expired) begin
            psel          <= 1'b0;
            penable       <= 1'b0;
            bus_read_data <= '0;
            bus_status    <= 2'b10;
            bus_done      <= 1'b1;
            state         <= COMPLETE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        COMPLETE: begin
          bus_done <= 1'b0;
          paddr    <= '0;
          pwdata   <= '0;
          pstrb    <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Scoreboard bench for rggen_apb_bridge with a simple APB4 slave model.
// Completion results are queued at request time and checked on bus_done.
module tb_rggen_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_request = 1'b0;
  logic [15:0] bus_address = '0;
  logic        bus_direction = 1'b0;
  logic [31:0] bus_write_data = '0;
  logic [3:0]  bus_write_strobe = '0;
  logic        bus_done;
  logic [31:0] bus_read_data;
  logic [1:0]  bus_status;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH  (16),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus_request      (bus_request),
    .bus_address      (bus_address),
    .bus_direction    (bus_direction),
    .bus_write_data   (bus_write_data),
    .bus_write_strobe (bus_write_strobe),
    .bus_done         (bus_done),
    .bus_read_data    (bus_read_data),
    .bus_status       (bus_status),
    .psel             (psel),
    .penable          (penable),
    .pwrite           (pwrite),
    .paddr            (paddr),
    .pprot            (pprot),
    .pwdata           (pwdata),
    .pstrb            (pstrb),
    .pready           (pready),
    .pslverr          (pslverr),
    .prdata           (prdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: {read_data, status}
  logic [33:0] sb[$];
  int n_done = 0;

  always @(negedge clk) begin
    if (bus_done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        check("rdata", bus_read_data, e[33:2]);
        check("status", bus_status, e[1:0]);
      end
    end
  end

  // APB slave model; prdata is garbage while not ready
  int          wait_cfg = 0;
  logic        err_cfg = 1'b0;
  logic [31:0] rdata_cfg = '0;
  int          wcnt = 0;

  always @(negedge clk) begin
    if (psel && penable) begin
      if (wcnt >= wait_cfg) begin
        pready  = 1'b1;
        pslverr = err_cfg;
        prdata  = rdata_cfg ^ {16'h0, paddr};
      end else begin
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = $urandom;
        wcnt++;
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
      wcnt    = 0;
    end
  end

  // APB transfer monitor
  int          n_setup = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          gap = 0;
  int          min_gap = 1000;
  logic        prev_psel = 1'b0;
  logic        seen = 1'b0;
  logic [15:0] s_addr;
  logic        s_pwrite;
  logic [3:0]  s_pstrb;
  logic [31:0] s_wdata;

  always @(negedge clk) begin
    if (psel) begin
      if (!penable) begin
        n_setup++;
        s_addr   = paddr;
        s_pwrite = pwrite;
        s_pstrb  = pstrb;
        s_wdata  = pwdata;
        cur_len  = 0;
      end
      cur_len++;
      last_len = cur_len;
      if (!prev_psel && seen && gap < min_gap) min_gap = gap;
      gap  = 0;
      seen = 1'b1;
    end else begin
      gap++;
    end
    prev_psel = psel;
  end

  task automatic do_req(input logic [15:0] a, input logic dir,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] exp_rd, input logic [1:0] exp_st,
                        output int lat);
    bit got;
    sb.push_back({exp_rd, exp_st});
    bus_request      = 1'b1;
    bus_address      = a;
    bus_direction    = dir;
    bus_write_data   = wd;
    bus_write_strobe = st;
    lat = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus_done) begin
        got = 1;
        break;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus_request = 1'b0;
  endtask

  int lat;
  int d0, s0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", bus_done, 0);
    check("rst_psel", {psel, penable, pwrite}, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", {pwdata, pstrb}, 0);
    check("rst_rdata", {bus_read_data, bus_status}, 0);
    check("pprot", pprot, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: write, zero wait states
    wait_cfg = 0;
    err_cfg  = 0;
    do_req(16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, lat);
    check("t1_latency", lat, 3);
    check("t1_pwrite", s_pwrite, 1);
    check("t1_pstrb", s_pstrb, 4'hF);
    check("t1_paddr", s_addr, 16'h0010);
    check("t1_pwdata", s_wdata, 32'hDEADBEEF);
    check("t1_psel_len", last_len, 2);
    @(posedge clk);
    #1;

    // 2: read with 4 wait states
    wait_cfg  = 4;
    rdata_cfg = 32'h12345678 ^ 32'h24;
    do_req(16'h0024, 1'b0, 32'hFFFFFFFF, 4'hF, 32'h12345678, 2'b00, lat);
    check("t2_latency", lat, 7);
    check("t2_pstrb", s_pstrb, 0);
    check("t2_pwrite", s_pwrite, 0);
    check("t2_psel_len", last_len, 6);
    check("t2_rd_hold", bus_read_data, 32'h12345678);
    check("t2_paddr_clr", paddr, 0);
    @(posedge clk);
    #1;

    // 3: write with slave error
    wait_cfg = 1;
    err_cfg  = 1;
    d0 = n_done;
    do_req(16'h0030, 1'b1, 32'h0BADF00D, 4'h3, 32'h0, 2'b10, lat);
    repeat (3) @(posedge clk);
    #1;
    check("t3_one_done", n_done - d0, 1);
    check("t3_idle", {psel, penable, bus_done}, 0);
    check("t3_st_hold", bus_status, 2'b10);
    err_cfg = 0;

    // 4: back-to-back reads, request stays high across the boundary
    wait_cfg  = 0;
    rdata_cfg = 32'hA5A50000;
    s0      = n_setup;
    d0      = n_done;
    min_gap = 1000;
    seen    = 1'b0;
    do_req(16'h0040, 1'b0, 32'h0, 4'h0, 32'hA5A50040, 2'b00, lat);
    do_req(16'h0044, 1'b0, 32'h0, 4'h0, 32'hA5A50044, 2'b00, lat);
    repeat (4) @(posedge clk);
    #1;
    check("t4_xfers", n_setup - s0, 2);
    check("t4_dones", n_done - d0, 2);
    check("t4_gap_ok", min_gap >= 1, 1);

    // 5: reset during ACCESS
    wait_cfg         = 20;
    bus_request      = 1'b1;
    bus_address      = 16'h0050;
    bus_direction    = 1'b0;
    sb.push_back('0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_in_access", {psel, penable}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_drop", {psel, penable, bus_done}, 0);
    sb.delete();
    bus_request = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_cfg  = 1;
    rdata_cfg = 32'h00C0FFEE;
    do_req(16'h0000, 1'b0, 32'h0, 4'h0, 32'h00C0FFEE, 2'b00, lat);
    check("t5_latency", lat, 4);
    @(posedge clk);
    #1;

    // 6: slave never ready
    wait_cfg = 100000;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    do_req(16'h0060, 1'b0, 32'h0, 4'h0, 32'h0, 2'b10, lat);
    check("t6_tmo_latency", lat, 10);
    check("t6_psel_low", psel, 0);
`else
    d0 = n_done;
    bus_request   = 1'b1;
    bus_address   = 16'h0060;
    bus_direction = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    check("t6_no_done", n_done - d0, 0);
    check("t6_waiting", {psel, penable}, 2'b11);
    bus_request = 1'b0;
`endif
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
